// File: rtl/rs_bank_nway.sv
// rs_bank_nway: superscalar reservation station bank with per-class (ALU/LSQ/MULT) issue.
// Define RS_AGE_ORDER_EN for oldest-first select; otherwise lowest-index select.
module rs_bank_nway #(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int INST_WIDTH     = 32,
  parameter int ALU_FUNC_WIDTH = 5
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          squash,
  input  logic [DISPATCH_WIDTH-1:0]                     dp_valid,
  input  logic [DISPATCH_WIDTH-1:0][PREG_IDX_WIDTH-1:0] dp_prega_idx,
  input  logic [DISPATCH_WIDTH-1:0][PREG_IDX_WIDTH-1:0] dp_pregb_idx,
  input  logic [DISPATCH_WIDTH-1:0][PREG_IDX_WIDTH-1:0] dp_pdest_idx,
  input  logic [DISPATCH_WIDTH-1:0]                     dp_prega_ready,
  input  logic [DISPATCH_WIDTH-1:0]                     dp_pregb_ready,
  input  logic [DISPATCH_WIDTH-1:0][INST_WIDTH-1:0]     dp_inst,
  input  logic [DISPATCH_WIDTH-1:0][ALU_FUNC_WIDTH-1:0] dp_alu_func,
  input  logic [DISPATCH_WIDTH-1:0]                     dp_rd_mem,
  input  logic [DISPATCH_WIDTH-1:0]                     dp_wr_mem,
  output logic                                          dp_stall,
  output logic [$clog2(NUM_ENTRIES):0]                  free_cnt,
  input  logic [CDB_WIDTH-1:0]                          cdb_valid,
  input  logic [CDB_WIDTH-1:0][PREG_IDX_WIDTH-1:0]      cdb_tag,
  input  logic [2:0]                                    fu_ready,
  output logic [2:0]                                    is_valid,
  output logic [2:0][INST_WIDTH-1:0]                    is_inst,
  output logic [2:0][ALU_FUNC_WIDTH-1:0]                is_alu_func,
  output logic [2:0][PREG_IDX_WIDTH-1:0]                is_prega_idx,
  output logic [2:0][PREG_IDX_WIDTH-1:0]                is_pregb_idx,
  output logic [2:0][PREG_IDX_WIDTH-1:0]                is_pdest_idx,
  output logic [2:0]                                    is_rd_mem,
  output logic [2:0]                                    is_wr_mem
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = IW + 1;
  localparam logic [INST_WIDTH-1:0]     NOP_INST   = INST_WIDTH'(32'h0000_0013);
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADD    = '0;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MUL    = ALU_FUNC_WIDTH'(10);
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MULH   = ALU_FUNC_WIDTH'(11);
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MULHSU = ALU_FUNC_WIDTH'(12);
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MULHU  = ALU_FUNC_WIDTH'(13);

  logic [NUM_ENTRIES-1:0]                     busy, busy_n, rdy_a, rdy_b, rd_mem, wr_mem;
  logic [NUM_ENTRIES-1:0][PREG_IDX_WIDTH-1:0] tag_a, tag_b, pdest;
  logic [NUM_ENTRIES-1:0][INST_WIDTH-1:0]     inst;
  logic [NUM_ENTRIES-1:0][ALU_FUNC_WIDTH-1:0] func;
  logic [NUM_ENTRIES-1:0]                     wake_a, wake_b, ent_rdy, avail, alloc_mask, iss;
  logic [NUM_ENTRIES-1:0][2:0]                ent_cls;
  logic [DISPATCH_WIDTH-1:0][IW-1:0]          slot_ent;
  logic [CW-1:0]                              dp_cnt;
  logic [2:0]                                 any_rdy, fire;
  logic [2:0][IW-1:0]                         sel;
  logic                                       alloc;
`ifdef RS_AGE_ORDER_EN
  logic [NUM_ENTRIES-1:0][IW-1:0]             age, age_n;
  logic [CW-1:0]                              rk;
`endif

  function automatic logic cdb_hit(input logic [CDB_WIDTH-1:0] v,
                                   input logic [CDB_WIDTH-1:0][PREG_IDX_WIDTH-1:0] t,
                                   input logic [PREG_IDX_WIDTH-1:0] tag);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) cdb_hit |= v[c] && t[c] == tag;
  endfunction

  // Wakeup is visible combinationally so an entry can issue in its broadcast cycle
  always_comb begin
    {wake_a, wake_b, ent_rdy} = '0;
    ent_cls = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      wake_a[e]  = rdy_a[e] || cdb_hit(cdb_valid, cdb_tag, tag_a[e]);
      wake_b[e]  = rdy_b[e] || cdb_hit(cdb_valid, cdb_tag, tag_b[e]);
      ent_rdy[e] = busy[e] && wake_a[e] && wake_b[e];
      ent_cls[e] = (rd_mem[e] || wr_mem[e]) ? 3'b010 :
                   (func[e] inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) ? 3'b100 : 3'b001;
    end
  end

  always_comb begin
    any_rdy = '0;
    sel = '0;
    for (int c = 0; c < 3; c++)
      for (int e = 0; e < NUM_ENTRIES; e++)
`ifdef RS_AGE_ORDER_EN
        if (ent_rdy[e] && ent_cls[e][c] && (!any_rdy[c] || age[e] < age[sel[c]])) begin
`else
        if (ent_rdy[e] && ent_cls[e][c] && !any_rdy[c]) begin
`endif
          any_rdy[c] = 1'b1;
          sel[c] = IW'(e);
        end
  end

  assign is_valid = any_rdy & {3{~(squash | reset)}};
  assign fire     = is_valid & fu_ready;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      is_inst[c]      = is_valid[c] ? inst[sel[c]] : NOP_INST;
      is_alu_func[c]  = is_valid[c] ? func[sel[c]] : ALU_ADD;
      is_prega_idx[c] = is_valid[c] ? tag_a[sel[c]] : '0;
      is_pregb_idx[c] = is_valid[c] ? tag_b[sel[c]] : '0;
      is_pdest_idx[c] = is_valid[c] ? pdest[sel[c]] : '0;
      is_rd_mem[c]    = is_valid[c] && rd_mem[sel[c]];
      is_wr_mem[c]    = is_valid[c] && wr_mem[sel[c]];
    end
  end

  // Each valid slot claims the lowest entry still unclaimed; freed-this-cycle entries stay busy
  always_comb begin
    avail = ~busy;
    slot_ent = '0;
    dp_cnt = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      dp_cnt = dp_cnt + CW'(dp_valid[s]);
      for (int e = NUM_ENTRIES - 1; e >= 0; e--)
        if (avail[e]) slot_ent[s] = IW'(e);
      if (dp_valid[s]) avail[slot_ent[s]] = 1'b0;
    end
    dp_stall = dp_cnt > free_cnt;
  end

  assign alloc = !dp_stall && !squash;

  always_comb begin
    alloc_mask = '0;
    iss = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++)
      if (alloc && dp_valid[s]) alloc_mask[slot_ent[s]] = 1'b1;
    for (int c = 0; c < 3; c++)
      if (fire[c]) iss[sel[c]] = 1'b1;
    busy_n = squash ? '0 : (busy & ~iss) | alloc_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= '0;
      free_cnt <= CW'(NUM_ENTRIES);
    end else begin
      busy     <= busy_n;
      free_cnt <= CW'(NUM_ENTRIES) - CW'($countones(busy_n));
    end
    rdy_a <= wake_a;
    rdy_b <= wake_b;
    for (int s = 0; s < DISPATCH_WIDTH; s++)
      if (alloc && dp_valid[s]) begin
        tag_a[slot_ent[s]]  <= dp_prega_idx[s];
        tag_b[slot_ent[s]]  <= dp_pregb_idx[s];
        pdest[slot_ent[s]]  <= dp_pdest_idx[s];
        inst[slot_ent[s]]   <= dp_inst[s];
        func[slot_ent[s]]   <= dp_alu_func[s];
        rd_mem[slot_ent[s]] <= dp_rd_mem[s];
        wr_mem[slot_ent[s]] <= dp_wr_mem[s];
        rdy_a[slot_ent[s]]  <= dp_prega_ready[s] || dp_prega_idx[s] == '0 ||
                               cdb_hit(cdb_valid, cdb_tag, dp_prega_idx[s]);
        rdy_b[slot_ent[s]]  <= dp_pregb_ready[s] || dp_pregb_idx[s] == '0 ||
                               cdb_hit(cdb_valid, cdb_tag, dp_pregb_idx[s]);
      end
  end

`ifdef RS_AGE_ORDER_EN
  // Ages stay dense (0 = oldest): survivors shift down past each older issue, newcomers append
  always_comb begin
    age_n = age;
    rk = CW'($countones(busy)) - CW'($countones(fire));
    for (int e = 0; e < NUM_ENTRIES; e++)
      for (int c = 0; c < 3; c++)
        if (fire[c] && age[sel[c]] < age[e]) age_n[e] = age_n[e] - IW'(1);
    for (int s = 0; s < DISPATCH_WIDTH; s++)
      if (alloc && dp_valid[s]) begin
        age_n[slot_ent[s]] = IW'(rk);
        rk = rk + CW'(1);
      end
  end

  always_ff @(posedge clock) age <= age_n;
`endif
endmodule

// File: tb/tb_rs_bank_nway.sv
// tb_rs_bank_nway: directed stimulus for rs_bank_nway with a per-cycle reference model
// and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_rs_bank_nway;
  localparam int N = 16, DW = 2, CDBW = 2, PW = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;

  logic clock = 1'b0, reset = 1'b1, squash = 1'b0;
  logic [DW-1:0] dp_valid, dp_prega_ready, dp_pregb_ready, dp_rd_mem, dp_wr_mem;
  logic [DW-1:0][PW-1:0] dp_prega_idx, dp_pregb_idx, dp_pdest_idx;
  logic [DW-1:0][31:0] dp_inst;
  logic [DW-1:0][4:0] dp_alu_func;
  logic dp_stall;
  logic [4:0] free_cnt;
  logic [CDBW-1:0] cdb_valid;
  logic [CDBW-1:0][PW-1:0] cdb_tag;
  logic [2:0] fu_ready, is_valid, is_rd_mem, is_wr_mem;
  logic [2:0][31:0] is_inst;
  logic [2:0][4:0] is_alu_func;
  logic [2:0][PW-1:0] is_prega_idx, is_pregb_idx, is_pdest_idx;

  always #5 clock = ~clock;

  rs_bank_nway dut (
    .clock(clock), .reset(reset), .squash(squash),
    .dp_valid(dp_valid), .dp_prega_idx(dp_prega_idx), .dp_pregb_idx(dp_pregb_idx),
    .dp_pdest_idx(dp_pdest_idx), .dp_prega_ready(dp_prega_ready), .dp_pregb_ready(dp_pregb_ready),
    .dp_inst(dp_inst), .dp_alu_func(dp_alu_func), .dp_rd_mem(dp_rd_mem), .dp_wr_mem(dp_wr_mem),
    .dp_stall(dp_stall), .free_cnt(free_cnt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .fu_ready(fu_ready), .is_valid(is_valid), .is_inst(is_inst), .is_alu_func(is_alu_func),
    .is_prega_idx(is_prega_idx), .is_pregb_idx(is_pregb_idx), .is_pdest_idx(is_pdest_idx),
    .is_rd_mem(is_rd_mem), .is_wr_mem(is_wr_mem)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entry list with a dispatch sequence number standing in for age
  logic       m_busy [N], m_ra [N], m_rb [N], m_rd [N], m_wr [N];
  logic [5:0] m_ta [N], m_tb [N], m_td [N];
  logic [31:0] m_inst [N];
  logic [4:0] m_func [N];
  int         m_seq [N];
  int         seq_ctr = 0;
  bit         m_live = 0;

  function automatic bit hit(input logic [5:0] t);
    for (int c = 0; c < CDBW; c++) if (cdb_valid[c] && cdb_tag[c] == t) return 1;
    return 0;
  endfunction

  function automatic int cls_of(input logic rd, input logic wr, input logic [4:0] f);
    return (rd || wr) ? 1 : (f inside {MUL, MULH, MULHSU, MULHU}) ? 2 : 0;
  endfunction

  always @(negedge clock) begin : model
    int pick [3];
    int tgt [DW];
    int nbusy, slot_k, seen, p;
    logic [2:0] ev;
    bit stall;
    nbusy = 0;
    for (int e = 0; e < N; e++) nbusy += int'(m_busy[e]);
    stall = $countones(dp_valid) > N - nbusy;
    ev = '0;
    for (int c = 0; c < 3; c++) begin
      pick[c] = -1;
      for (int e = 0; e < N; e++)
        if (m_busy[e] && (m_ra[e] || hit(m_ta[e])) && (m_rb[e] || hit(m_tb[e])) &&
            cls_of(m_rd[e], m_wr[e], m_func[e]) == c)
`ifdef RS_AGE_ORDER_EN
          if (pick[c] < 0 || m_seq[e] < m_seq[pick[c]]) pick[c] = e;
`else
          if (pick[c] < 0) pick[c] = e;
`endif
      ev[c] = pick[c] >= 0 && !squash && !reset;
    end
    if (m_live && !reset) begin
      chk("dp_stall", dp_stall, stall);
      chk("free_cnt", free_cnt, N - nbusy);
      chk("is_valid", is_valid, ev);
      for (int c = 0; c < 3; c++)
        if (ev[c]) begin
          p = pick[c];
          chk($sformatf("payload[%0d]", c),
              {is_inst[c], is_alu_func[c], is_prega_idx[c], is_pregb_idx[c], is_pdest_idx[c], is_rd_mem[c], is_wr_mem[c]},
              {m_inst[p], m_func[p], m_ta[p], m_tb[p], m_td[p], m_rd[p], m_wr[p]});
        end
    end
    if (reset) m_live = 1;
    if (reset || squash) begin
      for (int e = 0; e < N; e++) m_busy[e] = 0;
    end else if (m_live) begin
      slot_k = 0;
      for (int s = 0; s < DW; s++) begin
        tgt[s] = -1;
        if (dp_valid[s] && !stall) begin
          seen = 0;
          for (int e = 0; e < N; e++)
            if (!m_busy[e]) begin
              if (seen == slot_k && tgt[s] < 0) tgt[s] = e;
              seen++;
            end
          slot_k++;
        end
      end
      for (int e = 0; e < N; e++)
        if (m_busy[e]) begin
          m_ra[e] = m_ra[e] || hit(m_ta[e]);
          m_rb[e] = m_rb[e] || hit(m_tb[e]);
        end
      for (int c = 0; c < 3; c++) if (ev[c] && fu_ready[c]) m_busy[pick[c]] = 0;
      for (int s = 0; s < DW; s++)
        if (tgt[s] >= 0) begin
          p = tgt[s];
          m_busy[p] = 1;
          m_ta[p] = dp_prega_idx[s];
          m_tb[p] = dp_pregb_idx[s];
          m_td[p] = dp_pdest_idx[s];
          m_ra[p] = dp_prega_ready[s] || dp_prega_idx[s] == 0 || hit(dp_prega_idx[s]);
          m_rb[p] = dp_pregb_ready[s] || dp_pregb_idx[s] == 0 || hit(dp_pregb_idx[s]);
          m_inst[p] = dp_inst[s];
          m_func[p] = dp_alu_func[s];
          m_rd[p] = dp_rd_mem[s];
          m_wr[p] = dp_wr_mem[s];
          m_seq[p] = seq_ctr++;
        end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp_valid = '0; dp_prega_idx = '0; dp_pregb_idx = '0; dp_pdest_idx = '0;
    dp_prega_ready = '0; dp_pregb_ready = '0; dp_inst = '0; dp_alu_func = '0;
    dp_rd_mem = '0; dp_wr_mem = '0; cdb_valid = '0; cdb_tag = '0; squash = 0;
  endtask

  task automatic slot(input int s, input logic [5:0] a, input logic ar, input logic [5:0] b,
                      input logic br, input logic [5:0] d, input logic [4:0] f,
                      input logic rd, input logic wr);
    dp_valid[s] = 1'b1;
    dp_prega_idx[s] = a; dp_prega_ready[s] = ar;
    dp_pregb_idx[s] = b; dp_pregb_ready[s] = br;
    dp_pdest_idx[s] = d; dp_alu_func[s] = f;
    dp_rd_mem[s] = rd; dp_wr_mem[s] = wr;
    dp_inst[s] = 32'hA000_0000 | 32'(d);
  endtask

  initial begin
    idle();
    fu_ready = 3'b111;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst free_cnt", free_cnt, 16);
    chk("rst is_valid", is_valid, 0);
    chk("rst dp_stall", dp_stall, 0);
    chk("rst is_inst", is_inst[0], NOP);
    chk("rst is_alu_func", is_alu_func[2], ADD);
    chk("rst is_pdest", is_pdest_idx[1], 0);

    // two ready ALU ops, issued one per cycle
    slot(0, 1, 1, 2, 1, 10, ADD, 0, 0);
    slot(1, 3, 1, 4, 1, 11, SUB, 0, 0);
    tick(); idle(); #1;
    chk("t1 free_cnt", free_cnt, 14);
    chk("t1 is_valid", is_valid, 3'b001);
    chk("t1 first pdest", is_pdest_idx[0], 10);
    tick();
    chk("t1 second pdest", is_pdest_idx[0], 11);
    chk("t1 free_cnt2", free_cnt, 15);
    tick();
    chk("t1 drained", free_cnt, 16);

    // 0-cycle wakeup-to-issue
    slot(0, 5, 0, 0, 0, 12, ADD, 0, 0);
    tick(); idle(); #1;
    chk("t2 waiting", is_valid, 0);
    tick();
    cdb_valid = 2'b01; cdb_tag[0] = 5; #1;
    chk("t2 wake issue", is_valid, 3'b001);
    chk("t2 pdest", is_pdest_idx[0], 12);
    tick(); idle(); #1;
    chk("t2 freed", free_cnt, 16);

    // fill all entries, then an over-subscribed group stalls
    for (int i = 0; i < 8; i++) begin
      idle();
      slot(0, 6'(32 + 2*i), 0, 0, 1, 6'(2*i), ADD, 0, 0);
      slot(1, 6'(33 + 2*i), 0, 0, 1, 6'(2*i + 1), ADD, 0, 0);
      tick();
    end
    idle();
    slot(0, 0, 1, 0, 1, 60, ADD, 0, 0);
    slot(1, 0, 1, 0, 1, 61, ADD, 0, 0);
    #1;
    chk("t3 stall", dp_stall, 1);
    chk("t3 full", free_cnt, 0);
    tick();
    chk("t3 no write", free_cnt, 0);
    idle(); cdb_valid = 2'b10; cdb_tag[1] = 35; #1;
    chk("t3 wake entry3", is_valid, 3'b001);
    chk("t3 entry3 pdest", is_pdest_idx[0], 3);
    tick(); idle(); #1;
    chk("t3 one free", free_cnt, 1);
    slot(1, 0, 1, 0, 1, 62, ADD, 0, 0);
    #1;
    chk("t3 accept", dp_stall, 0);
    tick(); idle(); #1;
    chk("t3 refull", free_cnt, 0);
    chk("t3 new pdest", is_pdest_idx[0], 62);
    squash = 1; #1;
    chk("t3 squash no issue", is_valid, 0);
    tick(); idle(); #1;
    chk("t3 squash free", free_cnt, 16);

    // one op per class with LSQ back-pressured
    fu_ready = 3'b000;
    slot(0, 1, 1, 2, 1, 21, ADD, 0, 0);
    slot(1, 3, 1, 4, 1, 22, ADD, 1, 0);
    tick(); idle();
    slot(0, 5, 1, 6, 1, 23, MUL, 0, 0);
    tick(); idle(); fu_ready = 3'b101; #1;
    chk("t4 all valid", is_valid, 3'b111);
    chk("t4 alu pdest", is_pdest_idx[0], 21);
    chk("t4 lsq pdest", is_pdest_idx[1], 22);
    chk("t4 mult pdest", is_pdest_idx[2], 23);
    chk("t4 rd_mem", is_rd_mem, 3'b010);
    tick();
    chk("t4 lsq held", is_valid, 3'b010);
    chk("t4 free_cnt", free_cnt, 15);
    tick();
    chk("t4 lsq still", is_pdest_idx[1], 22);
    fu_ready = 3'b111;
    tick();
    chk("t4 drained", free_cnt, 16);

    // squash with a pending dispatch and a would-be issue
    for (int i = 0; i < 5; i++) begin
      idle();
      slot(0, 6'(10 + 2*i), 0, 0, 1, 6'(40 + 2*i), ADD, 0, 0);
      slot(1, 6'(11 + 2*i), 0, 0, 1, 6'(41 + 2*i), ADD, 0, 0);
      tick();
    end
    idle(); #1;
    chk("t5 ten busy", free_cnt, 6);
    squash = 1;
    slot(0, 0, 1, 0, 1, 30, ADD, 0, 0);
    slot(1, 0, 1, 0, 1, 31, ADD, 0, 0);
    cdb_valid = 2'b01; cdb_tag[0] = 10; #1;
    chk("t5 squash is_valid", is_valid, 0);
    tick(); idle(); #1;
    chk("t5 free_cnt", free_cnt, 16);
    chk("t5 nothing", is_valid, 0);

    // select order: A lands in entry 5, younger B in entry 2
    fu_ready = 3'b110;
    idle(); slot(0, 40, 0, 0, 1, 40, ADD, 1, 0); slot(1, 41, 0, 0, 1, 41, ADD, 1, 0); tick();
    idle(); slot(0, 42, 0, 0, 1, 42, ADD, 1, 0); slot(1, 43, 0, 0, 1, 43, ADD, 1, 0); tick();
    idle(); slot(0, 44, 0, 0, 1, 44, ADD, 1, 0); tick();
    idle(); slot(0, 0, 1, 0, 1, 50, ADD, 0, 0); tick();
    idle(); cdb_valid = 2'b01; cdb_tag[0] = 42; #1;
    chk("t6 lsq wake", is_valid, 3'b011);
    chk("t6 lsq pdest", is_pdest_idx[1], 42);
    tick();
    idle(); slot(0, 0, 1, 0, 1, 51, SUB, 0, 0); tick();
    idle(); fu_ready = 3'b111; #1;
`ifdef RS_AGE_ORDER_EN
    chk("t6 first", is_pdest_idx[0], 50);
    tick();
    chk("t6 second", is_pdest_idx[0], 51);
`else
    chk("t6 first", is_pdest_idx[0], 51);
    tick();
    chk("t6 second", is_pdest_idx[0], 50);
`endif
    squash = 1;
    tick(); idle(); #1;
    chk("t6 cleared", free_cnt, 16);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
